// File: rtl/rob_pkg.sv
// rob_pkg: shared types for the multi-port reorder buffer.
//   rob_entry_t - per-entry status flags (payload fields are per-instance
//                 widths, so they live in separate arrays in the top)
//   rob_xcpt_e  - exception cause encodings carried on wb_xcpt_type
//   rob_state_e - retire/flush control states
//   ROB_ID_W    - entry id width for a given depth
package rob_pkg;

  typedef struct packed {
    logic valid;
    logic done;
    logic is_store;
    logic xcpt;
  } rob_entry_t;

  typedef enum logic [2:0] {
    XCPT_NONE     = 3'd0,
    XCPT_IFETCH   = 3'd1,
    XCPT_ILLEGAL  = 3'd2,
    XCPT_LD_FAULT = 3'd3,
    XCPT_ST_FAULT = 3'd4,
    XCPT_MISALIGN = 3'd5
  } rob_xcpt_e;

  typedef enum logic {
    ROB_RUN   = 1'b0,
    ROB_FLUSH = 1'b1
  } rob_state_e;

  function automatic int ROB_ID_W(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// rob_lookup: one combinational operand-forwarding read.
//   id         in  producer entry id
//   fwd_ok     in  per-entry valid && done && !xcpt
//   entry_data in  per-entry result
//   hit        out producer result is forwardable
//   data       out forwarded result, 0 on a miss
module rob_lookup #(
  parameter int ENTRIES = 8,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 32
) (
  input  logic [ID_W-1:0]                 id,
  input  logic [ENTRIES-1:0]              fwd_ok,
  input  logic [ENTRIES-1:0][DATA_W-1:0]  entry_data,
  output logic                            hit,
  output logic [DATA_W-1:0]               data
);

  assign hit  = fwd_ok[id];
  assign data = hit ? entry_data[id] : '0;

endmodule

// File: rtl/reorder_buffer_mp.sv
// reorder_buffer_mp: parametrised multi-port reorder buffer.
//   alloc_*      decode allocation in program order (alloc_id = tail)
//   wb_*         out-of-order writeback, WB_PORTS ports, lowest port wins
//   rf_*         registered in-order register-file retire
//   st_*         in-order store handoff to dcache (valid/ready)
//   xcpt_*       precise exception pulse, followed by a self-flush
//   lookup_*     operand forwarding, LOOKUP_PORTS ports
//   oldest_id, full, empty  occupancy status
//
// state     | meaning
// ROB_RUN   | normal allocate / writeback / retire
// ROB_FLUSH | head faulted: xcpt_valid high, everything frozen, next edge empties
module reorder_buffer_mp
  import rob_pkg::*;
#(
  parameter int ENTRIES      = 8,
  parameter int WB_PORTS     = 3,
  parameter int LOOKUP_PORTS = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int REG_W        = 5,
  parameter int XCPT_W       = 3,
  parameter int ID_W         = ROB_ID_W(ENTRIES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [ID_W-1:0]                  alloc_id,
  input  logic                             alloc_is_store,
  input  logic [REG_W-1:0]                 alloc_dest,
  input  logic [ADDR_W-1:0]                alloc_pc,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*ID_W-1:0]         wb_id,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_data,
  input  logic [WB_PORTS*ADDR_W-1:0]       wb_addr,
  input  logic [WB_PORTS-1:0]              wb_xcpt,
  input  logic [WB_PORTS*XCPT_W-1:0]       wb_xcpt_type,
  output logic                             rf_we,
  output logic [REG_W-1:0]                 rf_dest,
  output logic [DATA_W-1:0]                rf_data,
  output logic [ID_W-1:0]                  rf_id,
  output logic                             st_valid,
  input  logic                             st_ready,
  output logic [ADDR_W-1:0]                st_addr,
  output logic [DATA_W-1:0]                st_data,
  output logic                             xcpt_valid,
  output logic [XCPT_W-1:0]                xcpt_type,
  output logic [ADDR_W-1:0]                xcpt_pc,
  output logic [ADDR_W-1:0]                xcpt_addr,
  input  logic [LOOKUP_PORTS*ID_W-1:0]     lookup_id,
  output logic [LOOKUP_PORTS-1:0]          lookup_hit,
  output logic [LOOKUP_PORTS*DATA_W-1:0]   lookup_data,
  output logic [ID_W-1:0]                  oldest_id,
  output logic                             full,
  output logic                             empty
);

  rob_state_e                       state_q, state_d;
  rob_entry_t [ENTRIES-1:0]         ent_q;
  logic [ENTRIES-1:0][REG_W-1:0]    dest_q;
  logic [ENTRIES-1:0][ADDR_W-1:0]   pc_q;
  logic [ENTRIES-1:0][ADDR_W-1:0]   addr_q;
  logic [ENTRIES-1:0][DATA_W-1:0]   data_q;
  logic [ENTRIES-1:0][XCPT_W-1:0]   xtype_q;
  logic [ID_W-1:0]                  head_q, tail_q;
  logic [ID_W:0]                    count_q;

  logic       flush_pending, head_ready, head_xcpt, retire_rf, retire, alloc_fire;
  rob_entry_t head_ent;

  logic [ENTRIES-1:0]               wb_hit;
  logic [ENTRIES-1:0]               wb_sel_xcpt;
  logic [ENTRIES-1:0][XCPT_W-1:0]   wb_sel_xtype;
  logic [ENTRIES-1:0][DATA_W-1:0]   wb_sel_data;
  logic [ENTRIES-1:0][ADDR_W-1:0]   wb_sel_addr;
  logic [ENTRIES-1:0]               fwd_ok;

  assign flush_pending = (state_q == ROB_FLUSH);
  assign full          = (count_q == (ID_W+1)'(ENTRIES));
  assign empty         = (count_q == '0);
  assign alloc_ready   = !full && !flush_pending;
  assign alloc_id      = tail_q;
  assign oldest_id     = head_q;
  assign alloc_fire    = alloc_valid && alloc_ready;

  assign head_ent   = ent_q[head_q];
  assign head_ready = head_ent.valid && head_ent.done && !flush_pending;
  assign head_xcpt  = head_ready && head_ent.xcpt;
  assign st_valid   = head_ready && !head_ent.xcpt && head_ent.is_store;
  assign retire_rf  = head_ready && !head_ent.xcpt && !head_ent.is_store;
  assign retire     = retire_rf || (st_valid && st_ready);
  assign st_addr    = st_valid ? addr_q[head_q] : '0;
  assign st_data    = st_valid ? data_q[head_q] : '0;
  assign xcpt_valid = flush_pending;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ROB_RUN:   if (head_xcpt) state_d = ROB_FLUSH;
      ROB_FLUSH: state_d = ROB_RUN;
      default:   state_d = ROB_RUN;
    endcase
  end

  // Scan ports from highest to lowest so the lowest index overwrites a shared id.
  always_comb begin
    wb_hit       = '0;
    wb_sel_xcpt  = '0;
    wb_sel_xtype = '0;
    wb_sel_data  = '0;
    wb_sel_addr  = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid[p]) begin
        wb_hit[wb_id[p*ID_W +: ID_W]]       = 1'b1;
        wb_sel_xcpt[wb_id[p*ID_W +: ID_W]]  = wb_xcpt[p];
        wb_sel_xtype[wb_id[p*ID_W +: ID_W]] = wb_xcpt_type[p*XCPT_W +: XCPT_W];
        wb_sel_data[wb_id[p*ID_W +: ID_W]]  = wb_data[p*DATA_W +: DATA_W];
        wb_sel_addr[wb_id[p*ID_W +: ID_W]]  = wb_addr[p*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    fwd_ok = '0;
    for (int e = 0; e < ENTRIES; e++)
      fwd_ok[e] = ent_q[e].valid && ent_q[e].done && !ent_q[e].xcpt;
  end

  // Allocation only ever targets an invalid slot, so it cannot race a writeback
  // (which requires a valid slot) or the head retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_q   <= '0;
      dest_q  <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      xtype_q <= '0;
    end else if (flush_pending) begin
      ent_q <= '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (wb_hit[e] && ent_q[e].valid) begin
          ent_q[e].done <= 1'b1;
          ent_q[e].xcpt <= wb_sel_xcpt[e];
          xtype_q[e]    <= wb_sel_xtype[e];
          data_q[e]     <= wb_sel_data[e];
          addr_q[e]     <= wb_sel_addr[e];
        end
      end
      if (retire)
        ent_q[head_q].valid <= 1'b0;
      if (alloc_fire) begin
        ent_q[tail_q]  <= '{valid: 1'b1, done: 1'b0, is_store: alloc_is_store, xcpt: 1'b0};
        dest_q[tail_q] <= alloc_dest;
        pc_q[tail_q]   <= alloc_pc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ROB_RUN;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_we     <= 1'b0;
      rf_dest   <= '0;
      rf_data   <= '0;
      rf_id     <= '0;
      xcpt_type <= '0;
      xcpt_pc   <= '0;
      xcpt_addr <= '0;
    end else begin
      state_q <= state_d;
      rf_we   <= retire_rf;
      if (retire_rf) begin
        rf_dest <= dest_q[head_q];
        rf_data <= data_q[head_q];
        rf_id   <= head_q;
      end
      if (head_xcpt) begin
        xcpt_type <= xtype_q[head_q];
        xcpt_pc   <= pc_q[head_q];
        xcpt_addr <= addr_q[head_q];
      end
      if (flush_pending) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (alloc_fire) tail_q <= tail_q + ID_W'(1);
        if (retire)     head_q <= head_q + ID_W'(1);
        count_q <= count_q + {{ID_W{1'b0}}, alloc_fire} - {{ID_W{1'b0}}, retire};
      end
    end
  end

  for (genvar g = 0; g < LOOKUP_PORTS; g++) begin : g_lookup
    rob_lookup #(
      .ENTRIES (ENTRIES),
      .ID_W    (ID_W),
      .DATA_W  (DATA_W)
    ) u_lookup (
      .id         (lookup_id[g*ID_W +: ID_W]),
      .fwd_ok     (fwd_ok),
      .entry_data (data_q),
      .hit        (lookup_hit[g]),
      .data       (lookup_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/reorder_buffer_mp.md
# reorder_buffer_mp

Parametrised multi-port reorder buffer, the successor of the fixed 8-entry, 3-writeback reorder buffer in the write-back stage. Decode allocates entries in program order. Any number of execution ports (ALU, MUL, cache, …) write results back out of order. The block retires one instruction per cycle in order to the register file or the dcache store path. It also raises precise exceptions with a self-flush and forwards completed results to operand lookup ports.

## Interface
Parameters:
- ENTRIES, 8, buffer depth (power of two, ≥2); ID_W = $clog2(ENTRIES)
- WB_PORTS, 3, writeback ports
- LOOKUP_PORTS, 4, operand forwarding lookup ports
- DATA_W, 32, result width
- ADDR_W, 32, PC/address width
- REG_W, 5, destination register index width
- XCPT_W, 3, exception type width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- alloc_valid  in  1  decode requests an entry
- alloc_ready  out  1  = !full && !flush_pending
- alloc_id  out  ID_W  id granted (current tail)
- alloc_is_store  in  1  entry is a store
- alloc_dest  in  REG_W  destination register
- alloc_pc  in  ADDR_W  instruction PC
- wb_valid  in  WB_PORTS  per-port writeback strobe
- wb_id  in  WB_PORTS*ID_W  entry id per port
- wb_data  in  WB_PORTS*DATA_W  result / store data
- wb_addr  in  WB_PORTS*ADDR_W  store address or faulting address
- wb_xcpt  in  WB_PORTS  writeback carries an exception
- wb_xcpt_type  in  WB_PORTS*XCPT_W  exception cause
- rf_we  out  1  register-file write strobe
- rf_dest  out  REG_W  register-file write index
- rf_data  out  DATA_W  register-file write data
- rf_id  out  ID_W  id of the retired entry
- st_valid  out  1  store request to dcache
- st_ready  in  1  dcache accepts the store
- st_addr  out  ADDR_W  store address
- st_data  out  DATA_W  store data
- xcpt_valid  out  1  exception raised (1-cycle pulse)
- xcpt_type  out  XCPT_W  exception cause
- xcpt_pc  out  ADDR_W  PC of the faulting instruction
- xcpt_addr  out  ADDR_W  faulting address
- lookup_id  in  LOOKUP_PORTS*ID_W  operand producer id per port
- lookup_hit  out  LOOKUP_PORTS  producer entry is valid, done and has no exception
- lookup_data  out  LOOKUP_PORTS*DATA_W  forwarded result
- oldest_id  out  ID_W  head pointer
- full  out  1  buffer full
- empty  out  1  buffer empty

## Operation
- Buffer is circular, with head/tail pointers of ID_W bits and a count of ID_W+1 bits.
  - Wrap-around is natural overflow.
  - full = (count==ENTRIES); empty = (count==0).
- Each entry holds: valid, done, is_store, xcpt, xcpt_type, dest, pc, data, addr.
- **Allocation:** on alloc_valid && alloc_ready, set the entry at tail valid with done=0, then tail+1.
- **Writeback:**
  - A writeback sets done and captures data, addr, xcpt and xcpt_type.
  - Writebacks to invalid entries are ignored; these are stale entries after a flush.
  - When two ports carry the same id in one cycle, the lowest port index wins.
- **Retirement** is evaluated on the head entry when it is valid && done:
  - xcpt=1: set flush_pending. Nothing is written to the RF or the dcache.
  - is_store: drive st_valid, with st_addr/st_data taken from the entry. Retire on st_valid && st_ready. Hold st_valid and the payload stable until accepted.
  - otherwise: register rf_we=1 with dest/data/id, then head+1.
- **Flush:**
  - xcpt_valid = flush_pending, with type/pc/addr registered from the head.
  - On the next edge, clear every valid bit and reset head=tail=count=0.
  - While flush_pending: alloc_ready=0, retirement stalls, and writebacks are ignored.
- **Allocate and retire in the same cycle:** count is unchanged. Allocation into a full buffer is never accepted, even if the buffer retires in that cycle.
- **Lookup:** purely combinational on registered state, with no same-cycle writeback bypass. On a miss, lookup_data = 0.

## Timing
- Reset values: all entries invalid, head=tail=count=0, rf_we=0, st_valid=0, xcpt_valid=0, all data outputs 0, empty=1, full=0, alloc_ready=1, alloc_id=0, oldest_id=0.
- Writeback sampled at edge t; done is visible in cycle t+1.
- Non-store retire decided in cycle t+1; rf_we is high in cycle t+2 for exactly one cycle per retire.
- st_valid is asserted combinationally in cycle t+1. Minimum store latency from writeback is one cycle.
- Exception head done in cycle t+1 → xcpt_valid in t+2 → buffer empty and alloc_ready=1 in t+3.
- Throughput: one allocation and one retirement per cycle.
- Reset asserted mid-operation clears state immediately; no partial retire completes.

## Structure
- Package rob_pkg holds rob_entry_t (the entry struct), the xcpt_type encodings and the ROB_ID_W helper function.
- Sub-module rob_lookup: one combinational id→{hit,data} read per port, instantiated LOOKUP_PORTS times via generate.

## Test plan
- **Fill and drain:** 8 allocs with no writebacks → full=1 and alloc_ready=0 after the 8th. Write back ids 7..0 in reverse order → rf_we pulses for ids 0..7 in order on consecutive cycles.
- **Same-id collision:** wb_valid=3'b011, both ports id=2, data 0xAAAA / 0x5555 → rf_data=0xAAAA on retire of id 2.
- **Store backpressure:** head is a store with addr 0x100, data 0xDEAD; st_ready low for 4 cycles → st_valid and payload held stable, head unchanged. st_ready high → retire; next entry retires the following cycle.
- **Exception:** id 1 writeback with xcpt=1, type 3, pc 0x40, ids 2–4 already done → id 0 retires; xcpt_valid pulses once with type 3 and pc 0x40; ids 2–4 never reach the RF; empty=1 and alloc_id=0 two cycles later.
- **Lookup:** id 5 done with 0x1234 → lookup_hit=1, data 0x1234. An un-done id → hit=0, data 0. An id whose entry holds an exception → hit=0.
- **Wrap and reset:** 20 alloc/retire pairs with simultaneous alloc+retire → count stays constant and pointers wrap past 7 to 0. Assert reset in the middle of the run → all outputs return to their reset values asynchronously.
